// File: rtl/prio_encode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prio_encode_pkg
// Purpose  : Shared FSM state type and width helper for prio_encode_seq.
// Revision : 1.0
// ============================================================================
package prio_encode_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // $clog2 returns 0 for n<=1; a code bus must be at least one bit wide.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_encode_comb.sv
`default_nettype none
// ============================================================================
// Module   : prio_encode_comb
// Purpose  : Combinational N-to-W priority encoder, highest set index wins.
// Revision : 1.0
// ============================================================================
module prio_encode_comb
    import prio_encode_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_safe(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         any
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        code = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                code = W'(i);
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/prio_encode_seq.sv
`default_nettype none
// ============================================================================
// Module   : prio_encode_seq
// Purpose  : Registered priority encoder with pending capture, mask,
//            valid/ack handshake and EI/EO cascade outputs.
// Revision : 1.0
// ============================================================================
module prio_encode_seq
    import prio_encode_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = clog2_safe(N),
    parameter int EDGE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ei_n,
    input  logic [N-1:0] req_n,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         gs_n,
    output logic         eo_n,
    output logic [N-1:0] pending
);

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   w_capture;
    logic [N-1:0]   w_eligible;
    logic [N-1:0]   w_clear_vec;
    logic [W-1:0]   w_enc_code;
    logic           w_enc_any;
    logic           w_load;
    logic           w_release;
    logic           w_eo_n_next;
    logic [W-1:0]   r_code;
    logic           r_valid;
    logic           r_eo_n;

    generate
        if (EDGE != 0) begin : g_edge
            logic [N-1:0] r_req_q;

            // Resets to all-ones so a request held low through reset is seen as a fall.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_req_q <= '1;
                end else begin
                    r_req_q <= req_n;
                end
            end

            assign w_capture = r_req_q & ~req_n;
        end else begin : g_level
            assign w_capture = ~req_n;
        end
    endgenerate

    assign w_eligible = r_pending & ~mask;

    prio_encode_comb #(
        .N (N),
        .W (W)
    ) u_enc (
        .req  (w_eligible),
        .code (w_enc_code),
        .any  (w_enc_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!ei_n && w_enc_any) begin
                    w_next_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode feeding the registered outputs
    always_comb begin
        w_load      = (r_state == ST_IDLE) && (w_next_state == ST_GRANT);
        w_release   = (r_state == ST_GRANT) && ack;
        w_eo_n_next = ~(!ei_n && !w_enc_any && (w_next_state == ST_IDLE));
        w_clear_vec = '0;
        if (w_release) begin
            w_clear_vec[r_code] = 1'b1;
        end
    end

    // Capture is OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_eo_n    <= 1'b1;
        end else begin
            r_pending <= (r_pending & ~w_clear_vec) | w_capture;
            if (w_load) begin
                r_code <= w_enc_code;
            end
            r_valid <= (w_next_state == ST_GRANT);
            r_eo_n  <= w_eo_n_next;
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign gs_n    = ~r_valid;
    assign eo_n    = r_eo_n;
    assign pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_prio_encode_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_encode_seq
// Purpose  : Self-checking bench: directed table, level-mode sequence, random vs model.
// Revision : 1.0
// ============================================================================
module tb_prio_encode_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Edge-mode instance signals
    logic       e_rst, e_ei_n, e_ack;
    logic [7:0] e_req_n, e_mask;
    logic [2:0] e_code;
    logic       e_valid, e_gs_n, e_eo_n;
    logic [7:0] e_pend;

    // Level-mode instance signals
    logic       l_rst, l_ei_n, l_ack;
    logic [7:0] l_req_n, l_mask;
    logic [2:0] l_code;
    logic       l_valid, l_gs_n, l_eo_n;
    logic [7:0] l_pend;

    prio_encode_seq #(.N(8), .EDGE(1)) dut_e (
        .clk(clk), .rst(e_rst), .ei_n(e_ei_n), .req_n(e_req_n), .mask(e_mask),
        .ack(e_ack), .code(e_code), .valid(e_valid), .gs_n(e_gs_n),
        .eo_n(e_eo_n), .pending(e_pend)
    );

    prio_encode_seq #(.N(8), .EDGE(0)) dut_l (
        .clk(clk), .rst(l_rst), .ei_n(l_ei_n), .req_n(l_req_n), .mask(l_mask),
        .ack(l_ack), .code(l_code), .valid(l_valid), .gs_n(l_gs_n),
        .eo_n(l_eo_n), .pending(l_pend)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         rst;
        bit         ei_n;
        logic [7:0] req_n;
        logic [7:0] mask;
        bit         ack;
        logic [2:0] code;
        bit         valid;
        bit         eo_n;
        logic [7:0] pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit ei_n, input logic [7:0] req_n,
                       input logic [7:0] mask, input bit ack, input logic [2:0] code,
                       input bit valid, input bit eo_n, input logic [7:0] pend);
        vec_t v;
        v.rst = rst; v.ei_n = ei_n; v.req_n = req_n; v.mask = mask; v.ack = ack;
        v.code = code; v.valid = valid; v.eo_n = eo_n; v.pend = pend;
        vecs.push_back(v);
    endtask

    // Packs {code, valid, gs_n, eo_n, pending} for compact comparison.
    function automatic logic [13:0] pack(input logic [2:0] c, input logic v,
                                         input logic g, input logic e, input logic [7:0] p);
        return {c, v, g, e, p};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got code=%0d valid=%b gs_n=%b eo_n=%b pend=%h, expected code=%0d valid=%b gs_n=%b eo_n=%b pend=%h",
                     name, act[13:11], act[10], act[9], act[8], act[7:0],
                     exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Reference model: index 0 models EDGE=1, index 1 models EDGE=0.
    logic [7:0] m_pend[2];
    logic [7:0] m_reqq[2];
    int         m_code[2];
    bit         m_valid[2];
    bit         m_eo_n[2];

    task automatic model_step(input int k, input bit rst, input bit ei_n,
                              input logic [7:0] req_n, input logic [7:0] mask, input bit ack);
        int         hi;
        bit         rel;
        bit         to_idle;
        logic [7:0] cap;
        if (rst) begin
            m_pend[k] = 8'h00; m_reqq[k] = 8'hFF; m_code[k] = 0;
            m_valid[k] = 1'b0; m_eo_n[k] = 1'b1;
            return;
        end
        hi = -1;
        for (int i = 7; i >= 0; i--)
            if (hi < 0 && m_pend[k][i] && !mask[i]) hi = i;
        cap     = (k == 0) ? (m_reqq[k] & ~req_n) : ~req_n;
        rel     = m_valid[k] && ack;
        to_idle = m_valid[k] ? ack : !(!ei_n && hi >= 0);
        m_eo_n[k] = !(!ei_n && hi < 0 && to_idle);
        if (rel) m_pend[k][m_code[k]] = 1'b0;
        m_pend[k] = m_pend[k] | cap;
        if (!m_valid[k] && !ei_n && hi >= 0) begin
            m_code[k]  = hi;
            m_valid[k] = 1'b1;
        end else if (rel) begin
            m_valid[k] = 1'b0;
        end
        m_reqq[k] = req_n;
    endtask

    initial begin
        e_rst = 1; e_ei_n = 0; e_req_n = 8'hFF; e_mask = 8'h00; e_ack = 0;
        l_rst = 1; l_ei_n = 0; l_req_n = 8'hFF; l_mask = 8'h00; l_ack = 0;

        //   rst ei  req_n  mask  ack code v eo pend
        add(1, 0, 8'hFF, 8'h00, 0, 0, 0, 1, 8'h00);   // reset
        add(0, 0, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00);
        add(0, 0, 8'hDB, 8'h00, 0, 0, 0, 0, 8'h24);   // bits 5,2 fall
        add(0, 0, 8'hDB, 8'h00, 0, 5, 1, 1, 8'h24);
        add(0, 0, 8'hDB, 8'h00, 1, 5, 0, 1, 8'h04);
        add(0, 0, 8'hDB, 8'h00, 0, 2, 1, 1, 8'h04);
        add(0, 0, 8'hDB, 8'h00, 1, 2, 0, 1, 8'h00);
        add(0, 0, 8'hDB, 8'h00, 0, 2, 0, 0, 8'h00);
        add(0, 0, 8'hFF, 8'h00, 0, 2, 0, 0, 8'h00);
        add(0, 0, 8'hF7, 8'h00, 0, 2, 0, 0, 8'h08);   // bit 3
        add(0, 0, 8'hF7, 8'h00, 0, 3, 1, 1, 8'h08);
        add(0, 0, 8'h77, 8'h00, 0, 3, 1, 1, 8'h88);   // bit 7 during grant
        add(0, 0, 8'h77, 8'h00, 0, 3, 1, 1, 8'h88);
        add(0, 0, 8'h77, 8'h00, 1, 3, 0, 1, 8'h80);
        add(0, 0, 8'h77, 8'h00, 0, 7, 1, 1, 8'h80);
        add(0, 0, 8'hFF, 8'h00, 1, 7, 0, 1, 8'h00);
        add(0, 0, 8'hFF, 8'h00, 0, 7, 0, 0, 8'h00);
        add(0, 0, 8'h7F, 8'h80, 0, 7, 0, 0, 8'h80);   // bit 7 masked
        add(0, 0, 8'h7F, 8'h80, 0, 7, 0, 0, 8'h80);
        add(0, 0, 8'h7F, 8'h00, 0, 7, 1, 1, 8'h80);
        add(0, 0, 8'hFF, 8'h00, 1, 7, 0, 1, 8'h00);
        add(0, 0, 8'hFF, 8'h00, 0, 7, 0, 0, 8'h00);
        add(0, 1, 8'hEF, 8'h00, 0, 7, 0, 1, 8'h10);   // ei_n blocks bit 4
        add(0, 1, 8'hEF, 8'h00, 0, 7, 0, 1, 8'h10);
        add(0, 0, 8'hEF, 8'h00, 0, 4, 1, 1, 8'h10);
        add(0, 0, 8'hFF, 8'h00, 1, 4, 0, 1, 8'h00);
        add(0, 0, 8'hFF, 8'h00, 0, 4, 0, 0, 8'h00);
        add(0, 0, 8'hFD, 8'h00, 0, 4, 0, 0, 8'h02);   // bit 1
        add(0, 0, 8'hFD, 8'h00, 0, 1, 1, 1, 8'h02);
        add(1, 0, 8'hFD, 8'h00, 0, 0, 0, 1, 8'h00);   // reset mid-grant
        add(0, 0, 8'hFD, 8'h00, 0, 0, 0, 0, 8'h02);   // held low through reset
        add(0, 0, 8'hFD, 8'h00, 0, 1, 1, 1, 8'h02);
        add(0, 0, 8'hFF, 8'h00, 1, 1, 0, 1, 8'h00);
        add(0, 0, 8'hFF, 8'h00, 0, 1, 0, 0, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            e_rst = vecs[i].rst; e_ei_n = vecs[i].ei_n; e_req_n = vecs[i].req_n;
            e_mask = vecs[i].mask; e_ack = vecs[i].ack;
            @(posedge clk); #1;
            check($sformatf("table[%0d]", i), pack(e_code, e_valid, e_gs_n, e_eo_n, e_pend),
                  pack(vecs[i].code, vecs[i].valid, ~vecs[i].valid, vecs[i].eo_n, vecs[i].pend));
        end

        // Level mode: bit 1 held low with ack high re-grants every 2 cycles.
        @(negedge clk);
        l_rst = 0; l_req_n = 8'hFD; l_ack = 1;
        @(posedge clk); #1;
        check("level_capture", pack(l_code, l_valid, l_gs_n, l_eo_n, l_pend), pack(0, 0, 1, 0, 8'h02));
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check($sformatf("level_grant%0d", n), pack(l_code, l_valid, l_gs_n, l_eo_n, l_pend),
                  pack(1, 1, 0, 1, 8'h02));
            @(posedge clk); #1;
            check($sformatf("level_ack%0d", n), pack(l_code, l_valid, l_gs_n, l_eo_n, l_pend),
                  pack(1, 0, 1, 1, 8'h02));
        end
        @(posedge clk); #1;
        check("level_regrant", pack(l_code, l_valid, l_gs_n, l_eo_n, l_pend), pack(1, 1, 0, 1, 8'h02));
        @(negedge clk);
        l_rst = 1;
        @(posedge clk); #1;
        check("level_rst_in_grant", pack(l_code, l_valid, l_gs_n, l_eo_n, l_pend), pack(0, 0, 1, 1, 8'h00));

        // Random: both instances get identical stimulus, each checked against the model.
        for (int c = 0; c < 600; c++) begin
            logic       r_rst, r_ei, r_ack;
            logic [7:0] r_req, r_msk;
            @(negedge clk);
            r_rst = (c == 0) || ($urandom_range(63) == 0);
            r_ei  = ($urandom_range(7) == 0);
            r_ack = $urandom_range(1);
            r_req = e_req_n;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(5) == 0) r_req[b] = ~r_req[b];
            r_msk = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            e_rst = r_rst; e_ei_n = r_ei; e_req_n = r_req; e_mask = r_msk; e_ack = r_ack;
            l_rst = r_rst; l_ei_n = r_ei; l_req_n = r_req; l_mask = r_msk; l_ack = r_ack;
            @(posedge clk);
            model_step(0, r_rst, r_ei, r_req, r_msk, r_ack);
            model_step(1, r_rst, r_ei, r_req, r_msk, r_ack);
            #1;
            check($sformatf("rand_edge[%0d]", c), pack(e_code, e_valid, e_gs_n, e_eo_n, e_pend),
                  pack(3'(m_code[0]), m_valid[0], ~m_valid[0], m_eo_n[0], m_pend[0]));
            check($sformatf("rand_level[%0d]", c), pack(l_code, l_valid, l_gs_n, l_eo_n, l_pend),
                  pack(3'(m_code[1]), m_valid[1], ~m_valid[1], m_eo_n[1], m_pend[1]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
